// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bit
// positions, FSM encodings and the divisor floor.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_READY  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_RXIE      = 4;
  localparam int ST_TXIE      = 5;
  localparam int ST_TX_BUSY   = 6;
  localparam int ST_IRQ       = 7;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  // Divisors below the floor would leave no room for the half-bit sample.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO for received characters. A pop that coincides with a push
// on a full FIFO frees the slot, so both take effect.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     avail_next
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full       = (cnt_q == (AW+1)'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign count      = cnt_q;
  assign head       = mem_q[rd_q];
  assign avail_next = (cnt_d != '0);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_uart.sv
// CPU-bus UART: DATA/STATUS/DIV registers, TX holding register + shifter,
// oversampling-free RX shifter (mid-bit sampling) feeding uart_rx_fifo.
module bus_uart
  import uart_pkg::*;
#(
  parameter logic [15:0] DIV_DEFAULT = 16'd234,
  parameter int          RX_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  input  logic       rx,
  output logic       tx
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic        rxie_q, rxie_d, txie_q, txie_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  thr_q, thr_d;
  logic        thr_full_q, thr_full_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        irq_q, irq_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  logic        rx_s1_q, rx_s2_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;

  logic          rd_en, wr_en, rd_pop, tx_take, tx_done, rx_done, rx_push, fe_set;
  logic [7:0]    status;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty, fifo_avail_next;
  logic [CW-1:0] fifo_count;

  assign rd_en = cs & ~we;
  assign wr_en = cs & we;
  assign rdata = rdata_q;
  assign irq   = irq_q;
  assign tx    = tx_q;

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rx_push),
    .push_data  (rx_sh_q),
    .pop        (rd_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .avail_next (fifo_avail_next)
  );

  always_comb begin
    // TX: each state lasts tx_div_q clocks; tx_q is the registered line level
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_take    = 1'b0;
    tx_done    = (tx_cnt_q == tx_div_q - 16'd1);
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_take  = thr_full_q;
      end
      TX_START: if (tx_done) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA: if (tx_done) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_d     = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_done) begin
        tx_cnt_d = '0;
        tx_take  = thr_full_q;
        if (!thr_full_q) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading straight out of STOP gives gap-free back-to-back frames.
    if (tx_take) begin
      tx_sh_d    = thr_q;
      tx_div_d   = eff_div(div_q);
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_d       = 1'b0;
    end

    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    rx_half    = {1'b0, rx_div_q[15:1]};
    rx_done    = (rx_cnt_q == rx_div_q - 16'd1);
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          rx_div_d   = eff_div(div_q);
        end
      end
      RX_START: if (rx_cnt_q == rx_half - 16'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_done) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_done) begin
        rx_cnt_d = '0;
        if (rx_s2_q) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          fe_set     = 1'b1;
          rx_state_d = RX_BREAK;
        end
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    status               = '0;
    status[ST_RX_AVAIL]  = (fifo_count != '0);
    status[ST_TX_READY]  = ~thr_full_q;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_RXIE]      = rxie_q;
    status[ST_TXIE]      = txie_q;
    status[ST_TX_BUSY]   = (tx_state_q != TX_IDLE);
    status[ST_IRQ]       = irq_q;

    rd_pop  = rd_en && (addr == REG_DATA) && !fifo_empty;
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        REG_DATA:   rdata_d = fifo_empty ? 8'h00 : fifo_head;
        REG_STATUS: rdata_d = status;
        REG_DIV_LO: rdata_d = div_q[7:0];
        REG_DIV_HI: rdata_d = div_q[15:8];
      endcase
    end

    // Holding-register readiness is judged after this cycle's transfer.
    thr_d      = thr_q;
    thr_full_d = thr_full_q & ~tx_take;
    rxie_d      = rxie_q;
    txie_d      = txie_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    div_d       = div_q;
    if (wr_en) begin
      case (addr)
        REG_DATA: if (!thr_full_d) begin
          thr_d      = wdata;
          thr_full_d = 1'b1;
        end
        REG_STATUS: begin
          rxie_d = wdata[0];
          txie_d = wdata[1];
          if (wdata[7]) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
          end
        end
        REG_DIV_LO: div_d[7:0]  = wdata;
        REG_DIV_HI: div_d[15:8] = wdata;
      endcase
    end
    if (rx_push && fifo_full && !rd_pop) overrun_d = 1'b1;
    if (fe_set) frame_err_d = 1'b1;

    irq_d = (rxie_d & fifo_avail_next) | (txie_d & ~thr_full_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxie_q      <= 1'b0;
      txie_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      div_q       <= DIV_DEFAULT;
      thr_q       <= '0;
      thr_full_q  <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= DIV_DEFAULT;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_q        <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= DIV_DEFAULT;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
    end else begin
      rxie_q      <= rxie_d;
      txie_q      <= txie_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      div_q       <= div_d;
      thr_q       <= thr_d;
      thr_full_q  <= thr_full_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_q        <= tx_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Scenario bench for bus_uart: RX bytes and TX frames are queued as expected
// values when driven and compared as the DUT produces them.
module tb_bus_uart;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset, cs, we, rx;
  logic [1:0] addr;
  logic [7:0] wdata, rdata;
  logic       irq, tx;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  always #5 clk = ~clk;

  bus_uart #(.DIV_DEFAULT(16'd234), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .rx(rx), .tx(tx)
  );

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each serial bit held for 8 clocks (DIV=8).
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] exp_regs [4];
    exp_regs = '{8'h00, 8'h02, 8'hEA, 8'h00};
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
    idle(3);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), d);
      total++;
      if (d !== exp_regs[a]) begin bad++; $display("FAIL rst_reg%0d got=%h exp=%h", a, d, exp_regs[a]); end
    end
  endtask

  task automatic test_div();
    logic [7:0] d;
    bus_wr(REG_DIV_LO, 8'h08);
    bus_wr(REG_DIV_HI, 8'h00);
    bus_rd(REG_DIV_LO, d);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL div_lo got=%h exp=08", d); end
    bus_rd(REG_DIV_HI, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL div_hi got=%h exp=00", d); end
  endtask

  task automatic test_tx_ready();
    logic [7:0] d;
    int n;
    bus_wr(REG_DATA, 8'h55);
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL txrdy_loaded got=%h exp=00", d); end
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h42) begin bad++; $display("FAIL txrdy_busy got=%h exp=42", d); end
    n = 0;
    do begin
      bus_rd(REG_STATUS, d);
      n++;
    end while (d[ST_TX_BUSY] && n < 300);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL txrdy_done got=%h exp=02 reads=%0d", d, n); end
  endtask

  // One or two bytes; the second write lands on the edge that empties holding.
  task automatic test_tx_frame(input int nb, input logic [7:0] d0, input logic [7:0] d1);
    logic [9:0] fr;
    logic [7:0] b;
    cs = 1'b1; we = 1'b1; addr = REG_DATA; wdata = d0;
    tx_exp_q.push_back(d0);
    @(posedge clk); #1;
    if (nb == 2) begin
      wdata = d1;
      tx_exp_q.push_back(d1);
    end else cs = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    fr = '1;
    for (int k = 0; k < nb * 80; k++) begin
      if (k % 80 == 0) begin
        b  = tx_exp_q.pop_front();
        fr = {1'b1, b, 1'b0};
      end
      @(negedge clk);
      total++;
      if (tx !== fr[(k % 80) / 8]) begin
        bad++; $display("FAIL tx_frame byte=%h cyc=%0d got=%b exp=%b", b, k, tx, fr[(k % 80) / 8]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_idle cyc=%0d got=%b exp=1", k, tx); end
    end
    idle(1);
  endtask

  task automatic pop_check(input string nm);
    logic [7:0] d, e;
    bus_rd(REG_DATA, d);
    e = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'h00;
    total++; if (d !== e) begin bad++; $display("FAIL %s got=%h exp=%h", nm, d, e); end
  endtask

  task automatic test_rx_single();
    logic [7:0] d;
    rx_exp_q.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    idle(2);
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL rx_avail got=%h exp=03", d); end
    pop_check("rx_data");
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL rx_drained got=%h exp=02", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) rx_exp_q.push_back(8'(i));
      send_rx(8'(i), 1'b1);
    end
    idle(2);
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h07) begin bad++; $display("FAIL ovr_status got=%h exp=07", d); end
    for (int i = 0; i < 4; i++) pop_check("ovr_data");
    bus_rd(REG_DATA, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL ovr_empty got=%h exp=00", d); end
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h06) begin bad++; $display("FAIL ovr_sticky got=%h exp=06", d); end
    bus_wr(REG_STATUS, 8'h80);
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL ovr_clear got=%h exp=02", d); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_rx(8'h7E, 1'b0);
    idle(40);
    rx = 1'b1;
    idle(100);
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL fe_status got=%h exp=0A", d); end
    bus_rd(REG_DATA, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL fe_empty got=%h exp=00", d); end
    bus_wr(REG_STATUS, 8'h80);
    rx_exp_q.push_back(8'hC5);
    send_rx(8'hC5, 1'b1);
    idle(2);
    pop_check("fe_recover");
  endtask

  task automatic test_irq();
    logic [7:0] d;
    bus_wr(REG_STATUS, 8'h01);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_quiet got=%b exp=0", irq); end
    rx_exp_q.push_back(8'h42);
    send_rx(8'h42, 1'b1);
    idle(2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx got=%b exp=1", irq); end
    pop_check("irq_data");
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_pop got=%b exp=0", irq); end
    bus_wr(REG_STATUS, 8'h02);
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'hA2) begin bad++; $display("FAIL irq_txie got=%h exp=A2", d); end
    bus_wr(REG_STATUS, 8'h00);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    bus_wr(REG_DATA, 8'h00);
    idle(20);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midtx_low got=%b exp=0", tx); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midtx_reset got=%b exp=1", tx); end
    reset = 1'b0;
    bus_rd(REG_STATUS, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL midtx_status got=%h exp=02", d); end
    bus_rd(REG_DIV_LO, d);
    total++; if (d !== 8'hEA) begin bad++; $display("FAIL midtx_div got=%h exp=EA", d); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx_ready();
    test_tx_frame(1, 8'h55, 8'h00);
    test_tx_frame(2, 8'h55, 8'hC3);
    test_rx_single();
    test_overrun();
    test_frame_err();
    test_irq();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_uart.md
Name: bus_uart

Overview:
Memory-mapped UART peripheral for the 6502 terminal system. It sits downstream of the CPU bus address decode and is selected the same way as the LED latch and program RAM. It provides:
- a TX holding register plus shifter,
- an RX shifter feeding a small RX FIFO,
- a status/IRQ-control register and a programmable baud divisor.

All host accesses are synchronous to the CPU clock.

Parameters:
DIV_DEFAULT, 16'd234, clocks per bit after reset (27 MHz / 115200).
RX_DEPTH, 4, RX FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  CPU clock; all logic on rising edge
reset  in  1  synchronous, active-high
cs  in  1  chip select from address decode
we  in  1  1 = write, 0 = read (qualified by cs)
addr  in  2  register select (CPU AB[1:0])
wdata  in  8  write data (CPU DO)
rdata  out  8  read data (to CPU DI), registered
irq  out  1  level interrupt request, registered
rx  in  1  serial input, asynchronous
tx  out  1  serial output, idle high

Behaviour:
- Reset values:
  - rdata=0x00, irq=0, tx=1.
  - RX FIFO empty; TX holding register empty; both FSMs IDLE.
  - Sticky bits cleared; RXIE=TXIE=0; divisor=DIV_DEFAULT.
- Register map (addr):
  - 0 DATA. Read pops the FIFO head into rdata. If the FIFO is empty, rdata=0x00 and there is no pop. Write loads the TX holding register. A write while holding is full is ignored.
  - 1 STATUS, read layout: b0 RX_AVAIL, b1 TX_READY (holding empty), b2 OVERRUN (sticky), b3 FRAME_ERR (sticky), b4 RXIE, b5 TXIE, b6 TX_BUSY, b7 irq.
  - 1 STATUS, write layout: b0->RXIE, b1->TXIE, b7=1 clears OVERRUN and FRAME_ERR.
  - 2 DIV_LO, 3 DIV_HI: read/write divisor bytes. Effective divisor = max(div, 4).
- Read latency: rdata updates on the same edge that samples cs&~we. The value is visible to the CPU on its next posedge. rdata holds otherwise, including during writes.
- irq is registered: irq <= (RXIE & RX_AVAIL) | (TXIE & TX_READY). It uses next-state values, so a pop or TX load is reflected one clock later.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if holding is full, move holding into the shifter, clear holding, latch the divisor, go to START.
  - Each state lasts D clocks. DATA shifts 8 bits LSB first. STOP drives 1.
  - Back-to-back bytes: holding refills during a frame, so the next START follows STOP with no idle gap.
  - A write to DATA on the same edge that IDLE empties holding is accepted, because TX_READY is evaluated after the transfer.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - IDLE: on a low level, latch the divisor, go to START.
  - START: wait D/2 (integer) clocks, resample. If high, treat as a glitch and return to IDLE; if low, go to DATA.
  - DATA: sample every D clocks, 8 bits LSB first, then STOP.
  - STOP: sample after D clocks. If 1, push the byte. If 0, set FRAME_ERR, discard the byte, go to BREAK. BREAK waits for the line to return high, then IDLE.
- FIFO boundaries:
  - Push when full: byte dropped, OVERRUN set.
  - Simultaneous pop and push when full: both occur, no overrun.
  - Simultaneous pop and push when empty: rdata=0x00, the byte is stored.
  - Pointers wrap modulo RX_DEPTH; a count register distinguishes full from empty.
- Divisor writes take effect at the next frame start of each FSM; a frame in progress keeps its latched D.
- Reset asserted mid-frame: tx returns to 1 on the next edge, and all state returns to reset values.
- Accesses with cs=0 have no effect; FSMs keep running.

Decomposition:
- Package uart_pkg:
  - register address constants (REG_DATA=0, REG_STATUS=1, REG_DIV_LO=2, REG_DIV_HI=3);
  - STATUS bit index constants;
  - TX state enum (IDLE, START, DATA, STOP) and RX state enum (IDLE, START, DATA, STOP, BREAK);
  - MIN_DIV=4.
- One sub-module: uart_rx_fifo (parameterised depth, 8-bit, push/pop/full/empty/count, same-cycle push+pop rules above).

Test Plan:
- Reset, then read all four registers -> DATA=0x00, STATUS=0x02, DIV_LO=0xEA, DIV_HI=0x00; tx=1.
- DIV=8. Write 0x55 to DATA -> tx low 8 clocks, bits 1,0,1,0,1,0,1,0 each 8 clocks, high 8 clocks. TX_READY=0 for one clock after the write, then 1 once loaded.
- DIV=8. Drive frame 0xA3 on rx -> STATUS b0=1 after stop sample. DATA read returns 0xA3, then STATUS b0=0.
- DIV=8. Drive 5 frames (0x01..0x05) with no reads -> OVERRUN=1. Reads return 0x01..0x04, then 0x00. Write STATUS 0x80 -> OVERRUN=0.
- DIV=8. Frame 0x7E with stop bit 0, then line held low 40 clocks -> FRAME_ERR=1, FIFO empty, no false start until rx rises.
- Write STATUS 0x01, receive 0x42 -> irq=1. Read DATA -> irq=0 one clock later. Assert reset mid-TX frame -> tx=1 next clock, STATUS=0x02.
